// File: rtl/float_norm_round_if.sv
// Operand/result handshake bundle for float_norm_round; slave is the stage side.
interface float_norm_round_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+1:0]       in_mant;
  logic [2:0]              in_grs;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_float;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
    input  in_ready, out_valid, out_float, overflow, underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
    output in_ready, out_valid, out_float, overflow, underflow
  );
endinterface

// File: rtl/float_norm_round.sv
// Normalise + RNE round of an unnormalised FP sum into a packed IEEE single.
// FLOAT_NORM_BARREL_EN: single-cycle LZC/barrel-shift normalisation instead of one bit per cycle.
module float_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic clk,
  input  logic rst_n,
  float_norm_round_if.slave bus
);
  localparam int MW = FRAC_W + 2;
  localparam int XW = EXP_W + 1;
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, CHECK, NORM, ROUND, DONE} state_e;
  state_e state_q, state_d;

  logic                  sign_q, sign_d;
  logic [XW-1:0]         exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic                  g_q, g_d, r_q, r_d, s_q, s_d;
  logic [EXP_W+FRAC_W:0] res_q, res_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, vld_q, vld_d;

  logic          acc, done_ack, is_zero;
  logic          norm_flush, norm_g;
  logic [MW-1:0] norm_mant;
  logic [XW-1:0] norm_exp;
  logic          inc, rcarry;
  logic [MW-1:0] rsum;
  logic [XW-1:0] rexp;

  assign acc      = bus.in_valid && (state_q == IDLE);
  assign done_ack = vld_q && bus.out_ready;
  assign is_zero  = (mant_q == '0) && !g_q && !r_q && !s_q;

`ifdef FLOAT_NORM_BARREL_EN
  logic [FRAC_W+2:0] nv, shifted;
  logic [XW-1:0]     lzc;
  always_comb begin
    nv  = {mant_q[FRAC_W:0], g_q, r_q};
    lzc = XW'(FRAC_W + 3);
    for (int i = 0; i < FRAC_W + 3; i++)
      if (nv[i]) lzc = XW'(FRAC_W + 2 - i);
    shifted    = nv << lzc;
    norm_mant  = {1'b0, shifted[FRAC_W+2:2]};
    norm_g     = shifted[1];
    norm_exp   = exp_q - lzc;
    norm_flush = (exp_q <= lzc) || (shifted == '0);
  end
`else
  always_comb begin
    norm_mant  = {mant_q[MW-2:0], g_q};
    norm_g     = r_q;
    norm_exp   = exp_q - XW'(1);
    norm_flush = (exp_q <= XW'(1)) && !mant_q[FRAC_W];
  end
`endif

  // A rounding carry leaves the fraction all-zero, so the >>1 only moves the exponent.
  assign inc    = g_q && (r_q || s_q || mant_q[0]);
  assign rsum   = mant_q + MW'(inc);
  assign rcarry = rsum[MW-1];
  assign rexp   = exp_q + XW'(rcarry);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (acc) state_d = CHECK;
      CHECK: if (is_zero || exp_q == EXP_MAX)        state_d = DONE;
             else if (mant_q[MW-1] || mant_q[FRAC_W]) state_d = ROUND;
             else                                    state_d = NORM;
`ifdef FLOAT_NORM_BARREL_EN
      NORM:  state_d = norm_flush ? DONE : ROUND;
`else
      NORM:  if (norm_flush)             state_d = DONE;
             else if (norm_mant[FRAC_W]) state_d = ROUND;
`endif
      ROUND: state_d = DONE;
      DONE:  if (done_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d = sign_q; exp_d = exp_q; mant_d = mant_q;
    g_d = g_q; r_d = r_q; s_d = s_q;
    res_d = res_q; ovf_d = ovf_q; unf_d = unf_q;
    vld_d = (state_q == DONE) && !done_ack;
    case (state_q)
      IDLE: if (acc) begin
        sign_d = bus.in_sign;
        exp_d  = {1'b0, bus.in_exp};
        mant_d = bus.in_mant;
        {g_d, r_d, s_d} = bus.in_grs;
      end
      CHECK:
        if (is_zero) res_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
        else if (exp_q == EXP_MAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (mant_q[MW-1]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_q + XW'(1);
          g_d    = mant_q[0];
          r_d    = g_q;
          s_d    = r_q || s_q;
        end
      NORM:
        if (norm_flush) begin
          res_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          unf_d = 1'b1;
        end else begin
          mant_d = norm_mant;
          exp_d  = norm_exp;
          g_d    = norm_g;
          r_d    = 1'b0;
        end
      ROUND:
        if (rexp >= EXP_MAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (rexp == '0) begin
          res_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
          unf_d = 1'b1;
        end else
          res_d = {sign_q, rexp[EXP_W-1:0], rcarry ? rsum[FRAC_W:1] : rsum[FRAC_W-1:0]};
      DONE: if (done_ack) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign_q <= 1'b0; exp_q <= '0; mant_q <= '0;
      g_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0;
      res_q <= '0; ovf_q <= 1'b0; unf_q <= 1'b0; vld_q <= 1'b0;
    end else begin
      sign_q <= sign_d; exp_q <= exp_d; mant_q <= mant_d;
      g_q <= g_d; r_q <= r_d; s_q <= s_d;
      res_q <= res_d; ovf_q <= ovf_d; unf_q <= unf_d; vld_q <= vld_d;
    end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.out_float = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_float_norm_round.sv
// Directed-vector bench for float_norm_round: results, flags, latency, backpressure, reset.
module tb_float_norm_round;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  float_norm_round_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  float_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_sh(input int n);
`ifdef FLOAT_NORM_BARREL_EN
    return 4;
`else
    return 3 + n;
`endif
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input logic [2:0] grs,
                        input logic [31:0] ef, input logic eo, input logic eu,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = e;
    bus.in_mant = m; bus.in_grs = grs;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1 lat++;
    end while (!bus.out_valid && lat < 80);
    chk({tag, "_lat"},   64'(lat), 64'(elat));
    chk({tag, "_float"}, 64'(bus.out_float), 64'(ef));
    chk({tag, "_ovf"},   64'(bus.overflow), 64'(eo));
    chk({tag, "_unf"},   64'(bus.underflow), 64'(eu));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"},   64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_float"}, 64'(bus.out_float), 64'(ef));
      chk({tag, "_hold_rdy"},   64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    chk({tag, "_ack_vld"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_ack_rdy"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_ack_flg"}, 64'({bus.overflow, bus.underflow}), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0;
    bus.in_mant = '0; bus.in_grs = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_inrdy", 64'(bus.in_ready), 64'd1);
    chk("rst_vld",   64'(bus.out_valid), 64'd0);
    chk("rst_float", 64'(bus.out_float), 64'd0);
    chk("rst_flags", 64'({bus.overflow, bus.underflow}), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("one",     1'b0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 3, 0);
    run_op("carry",   1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 3, 0);
    run_op("ovf",     1'b0, 8'd254, 25'h1FFFFFE, 3'b000, 32'h7F800000, 1'b1, 1'b0, 3, 0);
    run_op("crnd",    1'b0, 8'd127, 25'h1FFFFFF, 3'b000, 32'h40800000, 1'b0, 1'b0, 3, 0);
    run_op("expmax",  1'b0, 8'd255, 25'h0800000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 2, 0);
    run_op("norm2",   1'b0, 8'd130, 25'h0200000, 3'b000, 32'h40000000, 1'b0, 1'b0, lat_sh(2), 0);
    run_op("tie_odd", 1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 3, 0);
    run_op("tie_evn", 1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 1'b0, 3, 0);
    run_op("above",   1'b0, 8'd127, 25'h0800000, 3'b101, 32'h3F800001, 1'b0, 1'b0, 3, 0);
    run_op("neg",     1'b1, 8'd128, 25'h0C00000, 3'b000, 32'hC0400000, 1'b0, 1'b0, 3, 0);
`ifdef FLOAT_NORM_BARREL_EN
    run_op("unf",     1'b1, 8'd2,   25'h0000100, 3'b000, 32'h80000000, 1'b0, 1'b1, 3, 0);
`else
    run_op("unf",     1'b1, 8'd2,   25'h0000100, 3'b000, 32'h80000000, 1'b0, 1'b1, 4, 0);
`endif
    run_op("zero",    1'b0, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 2, 0);
    run_op("bp",      1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 3, 10);

    // Abort a long normalisation with reset, then confirm the stage is clean.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = 8'd100;
    bus.in_mant = 25'h0000100; bus.in_grs = 3'b000;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",   64'(bus.out_valid), 64'd0);
    chk("mid_rst_inrdy", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_float", 64'(bus.out_float), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("post_rst", 1'b0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
